// File: rtl/neuromorphic_x1_ctrl_pkg.sv
// Shared types and widths for the NEUROMORPHIC_X1 macro sequencer.
package neuromorphic_x1_ctrl_pkg;

  localparam int MAC_DW   = 32;
  localparam int MAC_SELW = 4;
  localparam int NUM_REQ  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                rwb;
    logic [MAC_DW-1:0]   ad;
    logic [MAC_DW-1:0]   di;
    logic [MAC_SELW-1:0] sel;
  } req_t;

endpackage

// File: rtl/neuromorphic_x1_rr_arb.sv
// Two-input round-robin arbiter. The pointer remembers the last winner and
// only moves when the caller reports an accepted grant.
module neuromorphic_x1_rr_arb
  import neuromorphic_x1_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  logic last_grant;

  // A lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    grant = valid;
    if (&valid) grant = last_grant ? 2'b01 : 2'b10;
  end

  // Pointer starts at 1 so requester 0 takes the first contest.
  always_ff @(posedge clk) begin
    if (rst)          last_grant <= 1'b1;
    else if (advance) last_grant <= grant[1];
  end

endmodule

// File: rtl/neuromorphic_x1_ctrl.sv
// Sequencer and two-port arbiter for the NEUROMORPHIC_X1 macro: grants one
// request at a time, holds EN until func_ack or timeout, returns a 1-cycle
// response to the requester that owned the transaction.
module neuromorphic_x1_ctrl
  import neuromorphic_x1_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                CLKin,
  input  logic                RSTin,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_rwb,
  input  logic [MAC_DW-1:0]   req0_ad,
  input  logic [MAC_DW-1:0]   req0_di,
  input  logic [MAC_SELW-1:0] req0_sel,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_rwb,
  input  logic [MAC_DW-1:0]   req1_ad,
  input  logic [MAC_DW-1:0]   req1_di,
  input  logic [MAC_SELW-1:0] req1_sel,
  output logic                rsp0_valid,
  output logic [MAC_DW-1:0]   rsp0_do,
  output logic                rsp0_err,
  output logic                rsp1_valid,
  output logic [MAC_DW-1:0]   rsp1_do,
  output logic                rsp1_err,
  output logic                mac_en,
  output logic                mac_r_wb,
  output logic [MAC_DW-1:0]   mac_ad,
  output logic [MAC_DW-1:0]   mac_di,
  output logic [MAC_SELW-1:0] mac_sel,
  input  logic [MAC_DW-1:0]   mac_do,
  input  logic                mac_func_ack,
  output logic                busy
);

  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt;
  logic                            owner;
  logic [NUM_REQ-1:0]              valid, grant, ready;
  req_t [NUM_REQ-1:0]              req;
  req_t                            req_win;
  logic                            hs, ack, tmo;
  logic [NUM_REQ-1:0]              rsp_valid_q, rsp_err_q;
  logic [NUM_REQ-1:0][MAC_DW-1:0]  rsp_do_q;

  assign valid  = {req1_valid, req0_valid};
  assign req[0] = {req0_rwb, req0_ad, req0_di, req0_sel};
  assign req[1] = {req1_rwb, req1_ad, req1_di, req1_sel};

  neuromorphic_x1_rr_arb u_arb (
    .clk     (CLKin),
    .rst     (RSTin),
    .valid   (valid),
    .advance (hs),
    .grant   (grant)
  );

  // Ready only in IDLE and never while reset is held.
  assign ready   = (state == IDLE && !RSTin) ? grant : '0;
  assign hs      = |(ready & valid);
  assign req_win = grant[1] ? req[1] : req[0];
  // Ack outside BUSY is ignored; ack takes priority over an expiring timeout.
  assign ack     = (state == BUSY) && mac_func_ack;
  assign tmo     = (state == BUSY) && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge CLKin) begin
    if (RSTin) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = BUSY;
      BUSY:    if (ack || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Macro drive, timeout counter and response registers.
  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      mac_en      <= 1'b0;
      mac_r_wb    <= 1'b1;
      mac_ad      <= '0;
      mac_di      <= '0;
      mac_sel     <= '0;
      cnt         <= '0;
      owner       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_do_q    <= '0;
      rsp_err_q   <= '0;
    end else begin
      rsp_valid_q <= '0;
      rsp_do_q    <= '0;
      rsp_err_q   <= '0;
      if (hs) begin
        mac_en   <= 1'b1;
        mac_r_wb <= req_win.rwb;
        mac_ad   <= req_win.ad;
        mac_di   <= req_win.di;
        mac_sel  <= req_win.sel;
        owner    <= grant[1];
        cnt      <= '0;
      end else if (ack || tmo) begin
        // Writes and timeouts return zero data.
        mac_en             <= 1'b0;
        rsp_valid_q[owner] <= 1'b1;
        rsp_do_q[owner]    <= (ack && mac_r_wb) ? mac_do : '0;
        rsp_err_q[owner]   <= !ack;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_do    = rsp_do_q[0];
  assign rsp1_do    = rsp_do_q[1];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_err   = rsp_err_q[1];
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_neuromorphic_x1_ctrl.sv
// Bench for neuromorphic_x1_ctrl: vector table of single transactions,
// hand sequences for reset/arbitration, and a randomized cycle-level model.
module tb_neuromorphic_x1_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req0_valid, req0_ready, req0_rwb, req1_valid, req1_ready, req1_rwb;
  logic [31:0] req0_ad, req0_di, req1_ad, req1_di;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_do, rsp1_do;
  logic        mac_en, mac_r_wb, mac_func_ack, busy;
  logic [31:0] mac_ad, mac_di, mac_do;
  logic [3:0]  mac_sel;

  logic [1:0]       rdy, rsv, rer;
  logic [1:0][31:0] rdo;
  assign rdy = {req1_ready, req0_ready};
  assign rsv = {rsp1_valid, rsp0_valid};
  assign rer = {rsp1_err, rsp0_err};
  assign rdo = {rsp1_do, rsp0_do};

  always #5 clk = ~clk;

  neuromorphic_x1_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLKin(clk), .RSTin(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rwb(req0_rwb),
    .req0_ad(req0_ad), .req0_di(req0_di), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rwb(req1_rwb),
    .req1_ad(req1_ad), .req1_di(req1_di), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_do(rsp0_do), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_do(rsp1_do), .rsp1_err(rsp1_err),
    .mac_en(mac_en), .mac_r_wb(mac_r_wb), .mac_ad(mac_ad), .mac_di(mac_di),
    .mac_sel(mac_sel), .mac_do(mac_do), .mac_func_ack(mac_func_ack), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic rwb,
                         input logic [31:0] ad, input logic [31:0] di, input logic [3:0] sel);
    if (p == 0) begin
      req0_valid = v; req0_rwb = rwb; req0_ad = ad; req0_di = di; req0_sel = sel;
    end else begin
      req1_valid = v; req1_rwb = rwb; req1_ad = ad; req1_di = di; req1_sel = sel;
    end
  endtask

  typedef struct {
    int          port;
    logic        rwb;
    logic [31:0] ad, di;
    logic [3:0]  sel;
    int          ack_at;   // EN cycle on which ack is given, 0 = never
    logic [31:0] dov;
    int          exp_en;
    logic [31:0] exp_do;
    logic        exp_err;
  } vec_t;

  vec_t vt[7];

  int          r_en, r_pulse, r_stray, r_unstable;
  logic [31:0] r_do;
  logic        r_err;

  // One transaction on an otherwise idle controller.
  task automatic run_txn(input vec_t v, input string tag);
    int g;
    r_en = 0; r_pulse = 0; r_stray = 0; r_unstable = 0; r_do = '0; r_err = 1'b0;
    @(negedge clk);
    set_req(v.port, 1'b1, v.rwb, v.ad, v.di, v.sel);
    #1;
    g = 0;
    while (!rdy[v.port] && g < 20) begin
      @(negedge clk); #1; g++;
    end
    chk1({tag, "_handshake"}, rdy[v.port], 1'b1);
    for (int i = 0; i < TMO + 6; i++) begin
      @(negedge clk);
      // valid dropped; fields scrambled to show they no longer matter
      set_req(v.port, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
      mac_func_ack = 1'b0;
      mac_do = $urandom;
      if (mac_en) begin
        r_en++;
        if (mac_ad !== v.ad || mac_di !== v.di || mac_sel !== v.sel || mac_r_wb !== v.rwb)
          r_unstable++;
        if (r_en == v.ack_at) begin
          mac_func_ack = 1'b1;
          mac_do = v.dov;
        end
      end
      if (rsv[v.port]) begin r_pulse++; r_do = rdo[v.port]; r_err = rer[v.port]; end
      if (rsv[1 - v.port]) r_stray++;
      #1;
    end
    mac_func_ack = 1'b0;
    chk({tag, "_en_cycles"}, 32'(r_en), 32'(v.exp_en));
    chk({tag, "_rsp_pulses"}, 32'(r_pulse), 32'd1);
    chk({tag, "_other_rsp"}, 32'(r_stray), 32'd0);
    chk({tag, "_mac_stable"}, 32'(r_unstable), 32'd0);
    chk({tag, "_rsp_do"}, r_do, v.exp_do);
    chk1({tag, "_rsp_err"}, r_err, v.exp_err);
  endtask

  // random-test model state
  int          c, w, k, owner, d_cur, en_s, en_e, rsp_c, free_c, last;
  bit [1:0]    pend;
  logic        prwb[2];
  logic [31:0] pad[2], pdi[2];
  logic [3:0]  psel[2];
  logic        e_rwb, e_err;
  logic [31:0] e_ad, e_di, e_do, dov_cur;
  logic [3:0]  e_sel;

  // arbitration-sequence state
  int rem[2];
  int ng, nr, onehot_bad, route_bad, wdata_bad;
  int order[$], oq[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{0, 1'b1, 32'h0000_0005, 32'h0,         4'h0, 3, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0};
    vt[1] = '{1, 1'b1, 32'h0000_0100, 32'h1111_2222, 4'h3, 1, 32'h1234_5678, 1, 32'h1234_5678, 1'b0};
    vt[2] = '{0, 1'b0, 32'h0000_0020, 32'hA5A5_5A5A, 4'hF, 2, 32'hFFFF_FFFF, 2, 32'h0,         1'b0};
    vt[3] = '{1, 1'b0, 32'h0000_0031, 32'h0F0F_0F0F, 4'h1, 0, 32'h0,         TMO, 32'h0,       1'b1};
    vt[4] = '{0, 1'b1, 32'h0000_0007, 32'h0,         4'h2, 0, 32'h0,         TMO, 32'h0,       1'b1};
    vt[5] = '{0, 1'b1, 32'h0000_0008, 32'h0,         4'h4, TMO, 32'hCAFE_F00D, TMO, 32'hCAFE_F00D, 1'b0};
    vt[6] = '{1, 1'b1, 32'h0000_03FF, 32'h0,         4'h8, TMO - 1, 32'h7654_3210, TMO - 1, 32'h7654_3210, 1'b0};

    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    mac_func_ack = 1'b0;
    mac_do = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk1("rst_mac_en", mac_en, 1'b0);
    chk1("rst_mac_r_wb", mac_r_wb, 1'b1);
    chk("rst_mac_ad", mac_ad, 32'h0);
    chk("rst_mac_di", mac_di, 32'h0);
    chk("rst_mac_sel", 32'(mac_sel), 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", 32'(rsv), 32'h0);
    chk("rst_rsp0_do", rsp0_do, 32'h0);
    chk("rst_rsp_err", 32'(rer), 32'h0);
    rst = 1'b0;

    // single-transaction vectors
    for (int i = 0; i < 7; i++) run_txn(vt[i], $sformatf("vec%0d", i));

    // reset while BUSY: transaction discarded silently
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h55, 32'h0, 4'h1);
    #1;
    chk1("midrst_ready", req0_ready, 1'b1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk1("midrst_en_before", mac_en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("midrst_en_after", mac_en, 1'b0);
    chk1("midrst_busy_after", busy, 1'b0);
    r_pulse = 0;
    r_en = 0;
    for (int i = 0; i < 6; i++) begin
      mac_func_ack = 1'b1;
      mac_do = $urandom;
      @(negedge clk);
      if (rsv != 2'b00) r_pulse++;
      if (mac_en || busy) r_en++;
    end
    mac_func_ack = 1'b0;
    chk("midrst_no_rsp", 32'(r_pulse), 32'd0);
    chk("stray_ack_idle", 32'(r_en), 32'd0);

    // both requesters valid continuously, 4 writes each
    rem[0] = 4; rem[1] = 4;
    ng = 0; nr = 0; onehot_bad = 0; route_bad = 0; wdata_bad = 0;
    for (int i = 0; i < 200 && (ng < 8 || nr < 8); i++) begin
      @(negedge clk);
      set_req(0, rem[0] > 0, 1'b0, 32'h40 + 32'(rem[0]), 32'hA000_0000 + 32'(rem[0]), 4'h5);
      set_req(1, rem[1] > 0, 1'b0, 32'h80 + 32'(rem[1]), 32'hB000_0000 + 32'(rem[1]), 4'hA);
      mac_func_ack = mac_en;
      mac_do = 32'hFFFF_FFFF;
      #1;
      if (req0_ready && req1_ready) onehot_bad++;
      for (int p = 0; p < 2; p++) begin
        if (rsv[p]) begin
          nr++;
          if (oq.size() == 0 || oq[0] != p) route_bad++;
          else void'(oq.pop_front());
          if (rdo[p] !== 32'h0) wdata_bad++;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (rdy[p] && rem[p] > 0) begin
          order.push_back(p);
          oq.push_back(p);
          rem[p]--;
          ng++;
        end
      end
    end
    mac_func_ack = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    chk("arb_grants", 32'(ng), 32'd8);
    chk("arb_rsps", 32'(nr), 32'd8);
    chk("arb_onehot", 32'(onehot_bad), 32'd0);
    chk("arb_routing", 32'(route_bad), 32'd0);
    chk("arb_write_do", 32'(wdata_bad), 32'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("arb_order%0d", i), (order.size() > i) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i % 2));

    // randomized traffic against a cycle-level model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pend = '0; last = 1; free_c = 0;
    en_s = -10; en_e = -10; rsp_c = -10; owner = 0; d_cur = 1;
    dov_cur = '0; e_do = '0; e_err = 1'b0; e_rwb = 1'b1; e_ad = '0; e_di = '0; e_sel = '0;
    for (c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          prwb[p] = 1'($urandom); pad[p] = $urandom; pdi[p] = $urandom; psel[p] = 4'($urandom);
          pend[p] = ($urandom_range(0, 2) == 0);
          set_req(p, pend[p], prwb[p], pad[p], pdi[p], psel[p]);
        end
      end
      if (c >= en_s && c <= en_e) begin
        mac_func_ack = (d_cur <= TMO) && (c == en_s + d_cur - 1);
        mac_do = mac_func_ack ? dov_cur : $urandom;
      end else begin
        mac_func_ack = ($urandom_range(0, 3) == 0);
        mac_do = $urandom;
      end
      #1;
      w = -1;
      if (c >= free_c) begin
        if (pend == 2'b11) w = (last == 0) ? 1 : 0;
        else if (pend[0])  w = 0;
        else if (pend[1])  w = 1;
      end
      chk1("rnd_ready0", req0_ready, w == 0);
      chk1("rnd_ready1", req1_ready, w == 1);
      chk1("rnd_mac_en", mac_en, c >= en_s && c <= en_e);
      chk1("rnd_busy", busy, c < free_c);
      chk1("rnd_rsp0_valid", rsp0_valid, c == rsp_c && owner == 0);
      chk1("rnd_rsp1_valid", rsp1_valid, c == rsp_c && owner == 1);
      if (c == rsp_c) begin
        chk("rnd_rsp_do", rdo[owner], e_do);
        chk1("rnd_rsp_err", rer[owner], e_err);
      end
      if (c >= en_s && c <= en_e) begin
        chk1("rnd_mac_r_wb", mac_r_wb, e_rwb);
        chk("rnd_mac_ad", mac_ad, e_ad);
        chk("rnd_mac_di", mac_di, e_di);
        chk("rnd_mac_sel", 32'(mac_sel), 32'(e_sel));
      end
      if (w >= 0) begin
        last = w; owner = w; pend[w] = 1'b0;
        d_cur = $urandom_range(1, TMO + 3);   // beyond TMO means the macro never acks
        dov_cur = $urandom;
        k = (d_cur <= TMO) ? d_cur : TMO;
        en_s = c + 1; en_e = c + k; rsp_c = c + k + 1; free_c = c + k + 2;
        e_rwb = prwb[w]; e_ad = pad[w]; e_di = pdi[w]; e_sel = psel[w];
        e_err = (d_cur > TMO);
        e_do  = (d_cur <= TMO && prwb[w]) ? dov_cur : 32'h0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
